// File: rtl/loader_pkg.sv
// Shared constants and state type for the RAM stream loader and the 32K x 8 RAM.
package loader_pkg;

  localparam int unsigned DEF_ADDR_W    = 16;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_LEN_W     = 16;
  localparam int unsigned DEF_MEM_DEPTH = 32768;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/loader_addr_counter.sv
// RAM write pointer: loads the base address (reduced modulo MEM_DEPTH),
// then advances by one per accepted byte, wrapping from MEM_DEPTH-1 to 0.
module loader_addr_counter
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  // Pointer register: load has priority over increment
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= ADDR_W'(32'(base) % MEM_DEPTH);
    end else if (inc) begin
      ptr <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ram_stream_loader.sv
// Byte-stream to RAM loader: writes a valid/ready byte stream to consecutive
// RAM addresses from a programmed base and pulses done after the programmed
// length. Optional feature macro: LOADER_CHECKSUM_EN (running byte checksum).
module ram_stream_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned LEN_W     = DEF_LEN_W,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_write_signal,
  output logic              ram_read_signal,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  byte_count,
  output logic [DATA_W-1:0] checksum
);

  loader_state_t     state;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] ptr;
  logic              start_ok;
  logic              accept;
  logic              last_byte;

  assign start_ok  = start && (state == IDLE);
  assign in_ready  = (state == LOAD);
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_count == len_q - 1'b1);

  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign ram_read_signal = 1'b0;

  loader_addr_counter #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_addr_counter (
    .clk  (clk),
    .RST  (RST),
    .load (start_ok),
    .base (base_addr),
    .inc  (accept),
    .ptr  (ptr)
  );

  // Transfer FSM: zero-length transfers go straight to DONE
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      len_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          len_q <= length;
          state <= (length == '0) ? DONE : LOAD;
        end
        LOAD: if (last_byte) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM write port: one registered write per accepted byte, address/data hold when idle
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ram_write_signal <= 1'b0;
      ram_address      <= '0;
      ram_data         <= '0;
    end else begin
      ram_write_signal <= accept;
      if (accept) begin
        ram_address <= ptr;
        ram_data    <= in_data;
      end
    end
  end

  // Accepted-byte counter, cleared on start
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      byte_count <= '0;
    end else if (start_ok) begin
      byte_count <= '0;
    end else if (accept) begin
      byte_count <= byte_count + 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running modulo-2^DATA_W sum of accepted bytes, cleared on start
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + in_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_stream_loader.sv
// Self-checking bench for ram_stream_loader: expected RAM writes are queued at
// stimulus time and popped by an independent write monitor; a sparse RAM model
// captures committed writes for readback.
`timescale 1ns/1ps
module tb_ram_stream_loader;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned LW    = 16;
  localparam int unsigned DEPTH = 32768;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_write_signal;
  logic          ram_read_signal;
  logic          busy;
  logic          done;
  logic [LW-1:0] byte_count;
  logic [DW-1:0] checksum;

  ram_stream_loader #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .LEN_W     (LW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .RST              (RST),
    .start            (start),
    .base_addr        (base_addr),
    .length           (length),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .ram_address      (ram_address),
    .ram_data         (ram_data),
    .ram_write_signal (ram_write_signal),
    .ram_read_signal  (ram_read_signal),
    .busy             (busy),
    .done             (done),
    .byte_count       (byte_count),
    .checksum         (checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } wr_t;

  int            checks = 0;
  int            errors = 0;
  wr_t           exp_q[$];
  logic [DW-1:0] ram_model[int];
  int            commits = 0;
  logic          pend = 1'b0;
  logic [AW-1:0] pend_a = '0;
  logic [DW-1:0] pend_d = '0;
  logic [DW-1:0] tx[$];
  bit            pat[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every write pulse must match the next expected write
  always @(negedge clk) begin : monitor
    wr_t e;
    pend = 1'b0;
    if (!RST) begin
      chk("ram_read_low", ram_read_signal, 0);
      if (ram_write_signal === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", ram_address, e.addr);
          chk("wr_data", ram_data, e.data);
          chk("done_with_last", done, e.last);
        end
        pend   = 1'b1;
        pend_a = ram_address;
        pend_d = ram_data;
      end
    end
  end

  // RAM model commits a write at the edge that ends its pulse
  always @(posedge clk) begin
    if (!RST && pend) begin
      ram_model[int'(pend_a)] = pend_d;
      commits++;
    end
  end

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  task automatic xfer(input logic [AW-1:0] base, input int unsigned len,
                      input int unsigned stall_pct, input int inject_at, input string tag);
    int unsigned   idx = 0;
    int unsigned   cyc = 0;
    int            c0;
    logic [AW-1:0] a;
    logic [AW-1:0] last_a;
    logic [DW-1:0] ck = '0;
    bit            v;
    a = AW'(32'(base) % DEPTH);
    last_a = ram_address;
    for (int unsigned i = 0; i < len; i++) begin
      exp_q.push_back('{addr: a, data: tx[i], last: (i == len - 1)});
      ram_model.delete(int'(a));
      ck += tx[i];
      last_a = a;
      a = next_addr(a);
    end
`ifndef LOADER_CHECKSUM_EN
    ck = '0;
`endif
    c0 = commits;
    start = 1'b1; base_addr = base; length = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
    if (len != 0) begin
      while (idx < len && cyc < len * 20 + 50) begin
        if (pat.size() > 0) v = pat.pop_front();
        else v = ($urandom_range(99) >= stall_pct);
        in_valid = v;
        in_data  = tx[idx];
        if (inject_at >= 0 && cyc == inject_at) begin
          start = 1'b1; base_addr = base ^ 16'h1234; length = LW'(len + 7);
        end
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
        if (v) idx++;
      end
      in_valid = 1'b0;
      if (idx < len) chk({tag, "_timeout"}, idx, len);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_count_done"}, byte_count, len);
    chk({tag, "_cksum_done"}, checksum, ck);
    chk({tag, "_ready_done"}, in_ready, 0);
    if (len == 0) chk({tag, "_no_write"}, ram_write_signal, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_busy_clear"}, busy, 0);
    chk({tag, "_cksum_hold"}, checksum, ck);
    chk({tag, "_count_hold"}, byte_count, len);
    chk({tag, "_addr_hold"}, ram_address, last_a);
    chk({tag, "_outstanding"}, exp_q.size(), 0);
    chk({tag, "_commits"}, commits - c0, len);
    a = AW'(32'(base) % DEPTH);
    for (int unsigned i = 0; i < len; i++) begin
      if (ram_model.exists(int'(a))) chk({tag, "_readback"}, ram_model[int'(a)], tx[i]);
      else chk({tag, "_readback_missing"}, 1, 0);
      a = next_addr(a);
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr"}, ram_write_signal, 0);
    chk({tag, "_rd"}, ram_read_signal, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, ram_address, 0);
    chk({tag, "_data"}, ram_data, 0);
    chk({tag, "_count"}, byte_count, 0);
    chk({tag, "_cksum"}, checksum, 0);
  endtask

  task automatic reset_mid();
    int            c0;
    logic [AW-1:0] b;
    b = 16'h0200;
    tx.delete();
    for (int unsigned i = 0; i < 5; i++) begin
      tx.push_back(DW'($urandom_range(255)));
      exp_q.push_back('{addr: b + AW'(i), data: tx[i], last: (i == 4)});
      ram_model.delete(int'(b) + int'(i));
    end
    c0 = commits;
    start = 1'b1; base_addr = b; length = LW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_data = tx[0];
    @(posedge clk); #1;
    in_data = tx[1];
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    RST = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    chk("rst_mid_pending", exp_q.size(), 3);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_commits", commits - c0, 2);
    chk("rst_mid_rb0", ram_model.exists(int'(b)) ? ram_model[int'(b)] : 9'h100, tx[0]);
    chk("rst_mid_rb1", ram_model.exists(int'(b) + 1) ? ram_model[int'(b) + 1] : 9'h100, tx[1]);
    chk("rst_mid_rb2_absent", ram_model.exists(int'(b) + 2), 0);
    chk("rst_mid_idle", busy, 0);
  endtask

  initial begin
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;
    @(posedge clk); #1;

    tx = '{8'h11, 8'h22, 8'h33, 8'h44};
    xfer(16'h0010, 4, 0, -1, "t1");

    tx = '{8'hA5, 8'h5A, 8'hC3};
    pat = '{1, 0, 0, 1, 0, 1};
    xfer(16'h0100, 3, 0, -1, "t2");
    pat.delete();

    tx = '{8'h01, 8'h02, 8'h03, 8'h04};
    xfer(16'h7FFE, 4, 0, -1, "t3");

    tx.delete();
    xfer(16'h0055, 0, 0, -1, "t4");

    reset_mid();

    tx = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    xfer(16'h0400, 6, 30, 2, "t6");

    for (int r = 0; r < 8; r++) begin
      int unsigned n;
      n = $urandom_range(24, 1);
      tx.delete();
      for (int unsigned i = 0; i < n; i++) tx.push_back(DW'($urandom_range(255)));
      xfer(AW'($urandom_range(65535)), n, $urandom_range(60), -1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
